scan_sequencer: RTL

//  Upstream driver for the 3-to-8 decoder: steps a 3-bit index (sel) plus enable (sel_en)

---
 rtl/scan_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit decoder select through indices 0..7. Each index is held
// for a programmable dwell, masked indices are skipped, and it runs single-sweep or continuous.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         skip_mask,
    output logic [2:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    pick_t              from_zero;
    pick_t              from_next;

    // Lowest unmasked index at or above k. k is 4 bits wide, so k=8 has no successor.
    function automatic pick_t first_free(input logic [7:0] m, input logic [3:0] k);
        pick_t p;
        p = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i >= int'(k) && !m[i]) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

    // NOTE: combinational outputs are fully assigned on every pass, so no latch is inferred.
    always_comb begin
        from_zero = first_free(skip_mask, 4'd0);
        from_next = first_free(skip_mask, {1'b0, sel} + 4'd1);
    end

    // NOTE: all state uses non-blocking assignments, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 3'd0;
            sel_en     <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            cnt        <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (from_zero.found) begin
                            state  <= ACTIVE;
                            sel    <= from_zero.idx;
                            cnt    <= dwell;
                            sel_en <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            sweep_done <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        state  <= IDLE;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (from_next.found) begin
                        sel <= from_next.idx;
                        cnt <= dwell;
                    end else begin
                        sweep_done <= 1'b1;
                        if (continuous && from_zero.found) begin
                            sel <= from_zero.idx;
                            cnt <= dwell;
                        end else begin
                            state  <= IDLE;
                            sel_en <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
